// File: rtl/fp_mul_norm_round.sv
// Normalise and round stage behind the 24x24 mantissa multiplier.
// Produces packed single-precision results through a 2-deep pipeline with valid/ready.
module fp_mul_norm_round #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_valid,
  output logic                    out_ready_up,
  input  logic                    in_sign,
  input  logic signed [EXP_W+1:0] in_exp,
  input  logic [2*MANT_W+1:0]     in_product,
  input  logic                    in_is_nan,
  input  logic                    in_is_inf,
  input  logic                    in_is_zero,
  output logic                    out_valid,
  input  logic                    in_ready,
  output logic [EXP_W+MANT_W:0]   out_result,
  output logic                    out_overflow,
  output logic                    out_underflow,
  output logic                    out_inexact
);

  localparam int PW = 2 * (MANT_W + 1);
  // One spare bit over the input exponent so the +1 adjustments never wrap.
  localparam int EW = EXP_W + 3;
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  logic en;
  assign en           = !out_valid || in_ready;
  assign out_ready_up = en;

  logic                 s1_valid;
  logic                 s1_sign;
  logic signed [EW-1:0] s1_e;
  logic [MANT_W-1:0]    s1_m;
  logic                 s1_g;
  logic                 s1_s;
  logic                 s1_uf;
  logic                 s1_nan;
  logic                 s1_inf;
  logic                 s1_zero;

  logic signed [EW-1:0] exp_ext;
  logic signed [EW-1:0] n1_e;
  logic [MANT_W-1:0]    n1_m;
  logic                 n1_g;
  logic                 n1_s;
  logic                 n1_uf;

  assign exp_ext = {in_exp[EXP_W+1], in_exp};

  always_comb begin
    n1_e  = exp_ext;
    n1_m  = '0;
    n1_g  = 1'b0;
    n1_s  = 1'b0;
    n1_uf = 1'b0;
    if (in_product[PW-1]) begin
      n1_m = in_product[PW-2 -: MANT_W];
      n1_g = in_product[PW-2-MANT_W];
      n1_s = |in_product[PW-3-MANT_W:0];
      n1_e = exp_ext + EW'(1);
    end else if (in_product[PW-2]) begin
      n1_m = in_product[PW-3 -: MANT_W];
      n1_g = in_product[PW-3-MANT_W];
      n1_s = |in_product[PW-4-MANT_W:0];
    end else begin
      n1_uf = 1'b1;
    end
  end

  logic                 round_up;
  logic [MANT_W:0]      sum;
  logic [MANT_W-1:0]    frac;
  logic signed [EW-1:0] e_r;
  logic [EXP_W+MANT_W:0] n2_res;
  logic                 n2_ov;
  logic                 n2_uf;
  logic                 n2_ix;

  // Round-to-nearest-even; a carry out of the fraction renormalises by one binade.
  always_comb begin
    round_up = s1_g && (s1_s || s1_m[0]);
    sum      = {1'b0, s1_m} + {{MANT_W{1'b0}}, round_up};
    frac     = sum[MANT_W] ? '0 : sum[MANT_W-1:0];
    e_r      = s1_e + EW'(sum[MANT_W]);
    n2_res   = {s1_sign, e_r[EXP_W-1:0], frac};
    n2_ov    = 1'b0;
    n2_uf    = 1'b0;
    n2_ix    = s1_g || s1_s;
    if (s1_nan) begin
      n2_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
      n2_ix  = 1'b0;
    end else if (s1_inf) begin
      n2_res = {s1_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      n2_ix  = 1'b0;
    end else if (s1_zero) begin
      n2_res = {s1_sign, {(EXP_W+MANT_W){1'b0}}};
      n2_ix  = 1'b0;
    end else if (s1_uf || e_r[EW-1] || e_r == '0) begin
      n2_res = {s1_sign, {(EXP_W+MANT_W){1'b0}}};
      n2_uf  = 1'b1;
      n2_ix  = 1'b1;
    end else if (e_r >= EMAX) begin
      n2_res = {s1_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      n2_ov  = 1'b1;
      n2_ix  = 1'b1;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      s1_valid      <= 1'b0;
      s1_sign       <= 1'b0;
      s1_e          <= '0;
      s1_m          <= '0;
      s1_g          <= 1'b0;
      s1_s          <= 1'b0;
      s1_uf         <= 1'b0;
      s1_nan        <= 1'b0;
      s1_inf        <= 1'b0;
      s1_zero       <= 1'b0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (en) begin
      s1_valid      <= in_valid;
      s1_sign       <= in_sign;
      s1_e          <= n1_e;
      s1_m          <= n1_m;
      s1_g          <= n1_g;
      s1_s          <= n1_s;
      s1_uf         <= n1_uf;
      s1_nan        <= in_is_nan;
      s1_inf        <= in_is_inf;
      s1_zero       <= in_is_zero;
      out_valid     <= s1_valid;
      out_result    <= n2_res;
      out_overflow  <= n2_ov;
      out_underflow <= n2_uf;
      out_inexact   <= n2_ix;
    end
  end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Randomised scoreboard bench for fp_mul_norm_round with directed corner beats.
// Expected results come from an integer quotient/remainder rounding model.
module tb_fp_mul_norm_round;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready_up;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [47:0] in_product = '0;
  logic        in_is_nan = 1'b0;
  logic        in_is_inf = 1'b0;
  logic        in_is_zero = 1'b0;
  logic        out_valid;
  logic        in_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  fp_mul_norm_round dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .out_ready_up(out_ready_up),
    .in_sign(in_sign), .in_exp(in_exp), .in_product(in_product),
    .in_is_nan(in_is_nan), .in_is_inf(in_is_inf), .in_is_zero(in_is_zero),
    .out_valid(out_valid), .in_ready(in_ready), .out_result(out_result),
    .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
  );

  always #5 in_clk = ~in_clk;

  int          errors = 0;
  int          checks = 0;
  logic [34:0] exp_q[$];
  logic [34:0] cur_exp = '0;
  logic        hold_pending = 1'b0;
  logic [34:0] held = '0;
  logic        saw_block = 1'b0;
  int          hold_cycles = 0;
  logic        ready_rand = 1'b0;
  logic        ready_level = 1'b1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Returns {result, overflow, underflow, inexact}.
  function automatic logic [34:0] ref_model(input logic s, input int e_in, input logic [47:0] p,
                                            input logic nan, input logic inf, input logic zero);
    longint unsigned pl, q, rem, half;
    int   sh, e;
    logic ix;
    logic [22:0] fr;
    if (nan)  return {32'h7FC00000, 3'b000};
    if (inf)  return {s, 8'hFF, 23'd0, 3'b000};
    if (zero) return {s, 31'd0, 3'b000};
    if (p[47:46] == 2'b00) return {s, 31'd0, 3'b011};
    pl   = 64'(p);
    sh   = p[47] ? 24 : 23;
    e    = e_in + (p[47] ? 1 : 0);
    q    = pl >> sh;
    rem  = pl - (q << sh);
    half = 64'd1 << (sh - 1);
    ix   = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q >= 64'd16777216) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0, 3'b101};
    if (e <= 0)   return {s, 31'd0, 3'b011};
    fr = q[22:0];
    return {s, e[7:0], fr, 1'b0, 1'b0, ix};
  endfunction

  always @(negedge in_clk) begin
    logic [34:0] e;
    if (in_rst) begin
      exp_q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_data", 64'({out_result, out_overflow, out_underflow, out_inexact}), 64'(held));
      end
      if (out_valid && in_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("stale_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("result", 64'(out_result), 64'(e[34:3]));
          checkOutput("flags", 64'({out_overflow, out_underflow, out_inexact}), 64'(e[2:0]));
        end
      end
      hold_pending = out_valid && !in_ready;
      held = {out_result, out_overflow, out_underflow, out_inexact};
      if (in_valid && out_ready_up) exp_q.push_back(cur_exp);
    end
  end

  task automatic update_ready();
    if (hold_cycles > 0) begin
      hold_cycles--;
      in_ready = 1'b0;
    end else if (ready_rand) begin
      in_ready = ($urandom_range(0, 3) != 0);
    end else begin
      in_ready = ready_level;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge in_clk);
      #1;
      update_ready();
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [9:0] e, input logic [47:0] p,
                               input logic nan, input logic inf, input logic zero,
                               input logic [34:0] expv);
    logic accepted = 1'b0;
    in_sign = s; in_exp = e; in_product = p;
    in_is_nan = nan; in_is_inf = inf; in_is_zero = zero;
    cur_exp = expv;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge in_clk);
      if (out_ready_up) accepted = 1'b1;
      else saw_block = 1'b1;
      @(posedge in_clk);
      #1;
      update_ready();
    end
    if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic random_beat();
    logic [63:0] pr;
    logic [47:0] p;
    int r, k, e;
    logic nan, inf, zero;
    r    = $urandom_range(0, 99);
    nan  = (r < 4);
    inf  = (r >= 4 && r < 8);
    zero = (r >= 8 && r < 12) || ($urandom_range(0, 30) == 0);
    pr   = {$urandom(), $urandom()};
    p    = pr[47:0];
    k    = $urandom_range(0, 9);
    if (k < 4) p[47] = 1'b1;
    else if (k < 9) p[47:46] = 2'b01;
    else p[47:46] = 2'b00;
    if ($urandom_range(0, 3) == 0) begin
      if (p[47]) p[23:0] = 24'h800000;
      else p[22:0] = 23'h400000;
    end
    if ($urandom_range(0, 5) == 0) p[46:24] = '1;
    e = int'($urandom_range(0, 300)) - 20;
    applyStimulus(1'($urandom_range(0, 1)), 10'(e), p, nan, inf, zero,
                  ref_model(1'b0, 0, 48'd0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    logic [34:0] m;
    repeat (3) @(posedge in_clk);
    #1;
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_result", 64'(out_result), 64'd0);
    checkOutput("rst_flags", 64'({out_overflow, out_underflow, out_inexact}), 64'd0);
    checkOutput("rst_ready_up", 64'(out_ready_up), 64'd1);
    in_rst = 1'b0;
    idle(2);

    applyStimulus(1'b0, 10'd127, 48'h900000000000, 1'b0, 1'b0, 1'b0, {32'h40100000, 3'b000});
    applyStimulus(1'b0, 10'd127, 48'h400000400000, 1'b0, 1'b0, 1'b0, {32'h3F800000, 3'b001});
    applyStimulus(1'b0, 10'd127, 48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0, {32'h40000000, 3'b001});
    applyStimulus(1'b1, 10'd254, 48'h800000000000, 1'b0, 1'b0, 1'b0, {32'hFF800000, 3'b101});
    applyStimulus(1'b0, 10'd0,   48'h400000000000, 1'b0, 1'b0, 1'b0, {32'h00000000, 3'b011});
    applyStimulus(1'b0, 10'd127, 48'h900000000000, 1'b1, 1'b0, 1'b1, {32'h7FC00000, 3'b000});
    applyStimulus(1'b1, 10'd300, 48'h900000000000, 1'b0, 1'b1, 1'b0, {32'hFF800000, 3'b000});
    applyStimulus(1'b1, 10'd127, 48'h3FFFFFFFFFFF, 1'b0, 1'b0, 1'b0, {32'h80000000, 3'b011});
    idle(4);

    in_ready = 1'b0;
    hold_cycles = 4;
    saw_block = 1'b0;
    applyStimulus(1'b0, 10'd127, 48'h900000000000, 1'b0, 1'b0, 1'b0, {32'h40100000, 3'b000});
    applyStimulus(1'b0, 10'd127, 48'h400000400000, 1'b0, 1'b0, 1'b0, {32'h3F800000, 3'b001});
    applyStimulus(1'b0, 10'd127, 48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0, {32'h40000000, 3'b001});
    checkOutput("b2b_blocked", 64'(saw_block), 64'd1);
    idle(4);

    ready_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [63:0] pr;
      logic [47:0] p;
      int r, k, e;
      logic s, nan, inf, zero;
      r    = $urandom_range(0, 99);
      nan  = (r < 4);
      inf  = (r >= 4 && r < 8);
      zero = (r >= 8 && r < 12);
      pr   = {$urandom(), $urandom()};
      p    = pr[47:0];
      k    = $urandom_range(0, 9);
      if (k < 4) p[47] = 1'b1;
      else if (k < 9) p[47:46] = 2'b01;
      else p[47:46] = 2'b00;
      if ($urandom_range(0, 3) == 0) begin
        if (p[47]) p[23:0] = 24'h800000;
        else p[22:0] = 23'h400000;
      end
      if ($urandom_range(0, 5) == 0) begin
        if (p[47]) p[46:24] = '1;
        else p[45:23] = '1;
      end
      e = int'($urandom_range(0, 300)) - 20;
      s = 1'($urandom_range(0, 1));
      m = ref_model(s, e, p, nan, inf, zero);
      applyStimulus(s, 10'(e), p, nan, inf, zero, m);
      if ($urandom_range(0, 4) == 0) idle(1);
    end

    ready_rand = 1'b0;
    ready_level = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) idle(1);
    checkOutput("drain_random", 64'(exp_q.size()), 64'd0);

    ready_level = 1'b0;
    idle(1);
    applyStimulus(1'b0, 10'd127, 48'h900000000000, 1'b0, 1'b0, 1'b0, {32'h40100000, 3'b000});
    applyStimulus(1'b1, 10'd130, 48'hC00000000000, 1'b0, 1'b0, 1'b0,
                  ref_model(1'b1, 130, 48'hC00000000000, 1'b0, 1'b0, 1'b0));
    in_rst = 1'b1;
    @(posedge in_clk);
    #1;
    checkOutput("rst_flight_valid", 64'(out_valid), 64'd0);
    in_rst = 1'b0;
    ready_level = 1'b1;
    idle(6);
    checkOutput("rst_flight_idle", 64'(out_valid), 64'd0);

    applyStimulus(1'b0, 10'd100, 48'h600000000000, 1'b0, 1'b0, 1'b0,
                  ref_model(1'b0, 100, 48'h600000000000, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) idle(1);
    checkOutput("drain_final", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
